// File: rtl/branch_stack.sv
// branch_stack: per-branch checkpoints of the free list and ROB tail,
// kept current with retiring registers and restored on a mispredict.
// Ports: clock/reset (sync, active-high); br_dispatch_valid,
// br_free_list, br_rob_tail in, br_tag/stack_full out (allocation);
// resolve_valid/tag/mispredict in; phys_reg_retiring +
// num_retiring_valid in (retire frees); restore_flag,
// free_list_restore, rob_tail_restore, squash_mask out (registered).
// Optional: define BRANCH_STACK_STATS_EN to add stat_mispredicts,
// stat_correct, stat_full_stalls saturating counters.
module branch_stack #(
  parameter int DEPTH        = 4,
  parameter int PHYS_REGS    = 64,
  parameter int N            = 3,
  parameter int ROB_IDX_BITS = 5,
  parameter int TAG_BITS     = $clog2(DEPTH)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            br_dispatch_valid,
  input  logic [PHYS_REGS-1:0]            br_free_list,
  input  logic [ROB_IDX_BITS-1:0]         br_rob_tail,
  output logic [TAG_BITS-1:0]             br_tag,
  output logic                            stack_full,
  input  logic                            resolve_valid,
  input  logic [TAG_BITS-1:0]             resolve_tag,
  input  logic                            resolve_mispredict,
  input  logic [N*$clog2(PHYS_REGS)-1:0]  phys_reg_retiring,
  input  logic [$clog2(N+1)-1:0]          num_retiring_valid,
  output logic                            restore_flag,
  output logic [PHYS_REGS-1:0]            free_list_restore,
  output logic [ROB_IDX_BITS-1:0]         rob_tail_restore,
  output logic [DEPTH-1:0]                squash_mask
`ifdef BRANCH_STACK_STATS_EN
  ,
  output logic [31:0]                     stat_mispredicts,
  output logic [31:0]                     stat_correct,
  output logic [31:0]                     stat_full_stalls
`endif
);

  localparam int PW = $clog2(PHYS_REGS);
  localparam int CW = $clog2(N+1);

  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [PHYS_REGS-1:0]    snap_q  [DEPTH];
  logic [PHYS_REGS-1:0]    snap_d  [DEPTH];
  logic [ROB_IDX_BITS-1:0] tail_q  [DEPTH];
  logic [ROB_IDX_BITS-1:0] tail_d  [DEPTH];
  logic [DEPTH-1:0]        young_q [DEPTH];
  logic [DEPTH-1:0]        young_d [DEPTH];

  logic                    restore_q, restore_d;
  logic [PHYS_REGS-1:0]    frl_q, frl_d;
  logic [ROB_IDX_BITS-1:0] rtl_q, rtl_d;
  logic [DEPTH-1:0]        sq_q, sq_d;

  logic [PHYS_REGS-1:0]    ret_bits;
  logic [TAG_BITS-1:0]     alloc_tag;
  logic                    full;
  logic                    tgt_ok, mis, cor, do_alloc;
  logic [DEPTH-1:0]        oh_t, kill;

  always_comb begin
    ret_bits = '0;
    for (int i = 0; i < N; i++) begin
      if (CW'(i) < num_retiring_valid)
        ret_bits[phys_reg_retiring[i*PW +: PW]] = 1'b1;
    end
  end

  // Lowest free slot wins; scan downward so the last hit is lowest.
  always_comb begin
    alloc_tag = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (!valid_q[k]) alloc_tag = TAG_BITS'(k);
    end
  end

  assign full     = &valid_q;
  assign tgt_ok   = resolve_valid && valid_q[resolve_tag];
  assign mis      = tgt_ok && resolve_mispredict;
  assign cor      = tgt_ok && !resolve_mispredict;
  // A same-cycle mispredict squashes the dispatching branch too.
  assign do_alloc = br_dispatch_valid && !full && !mis;
  assign oh_t     = DEPTH'(1) << resolve_tag;
  assign sq_d     = mis ? (oh_t | young_q[resolve_tag]) : '0;
  assign kill     = sq_d | (cor ? oh_t : '0);

  always_comb begin
    valid_d = valid_q & ~kill;
    for (int k = 0; k < DEPTH; k++) begin
      snap_d[k]  = snap_q[k] | ret_bits;
      tail_d[k]  = tail_q[k];
      young_d[k] = young_q[k] & ~kill;
      // Released entries never gain the new branch as a younger one.
      if (do_alloc && valid_q[k] && !kill[k])
        young_d[k][alloc_tag] = 1'b1;
    end
    if (do_alloc) begin
      valid_d[alloc_tag] = 1'b1;
      snap_d[alloc_tag]  = br_free_list | ret_bits;
      tail_d[alloc_tag]  = br_rob_tail;
      young_d[alloc_tag] = '0;
    end
  end

  always_comb begin
    restore_d = mis;
    frl_d     = frl_q;
    rtl_d     = rtl_q;
    if (mis) begin
      frl_d = snap_q[resolve_tag] | ret_bits;
      rtl_d = tail_q[resolve_tag];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= '0;
      restore_q <= 1'b0;
      frl_q     <= '0;
      rtl_q     <= '0;
      sq_q      <= '0;
      for (int k = 0; k < DEPTH; k++) young_q[k] <= '0;
    end else begin
      valid_q   <= valid_d;
      restore_q <= restore_d;
      frl_q     <= frl_d;
      rtl_q     <= rtl_d;
      sq_q      <= sq_d;
      for (int k = 0; k < DEPTH; k++) young_q[k] <= young_d[k];
    end
  end

  // Payload is only meaningful while valid, so it needs no reset.
  always_ff @(posedge clock) begin
    for (int k = 0; k < DEPTH; k++) begin
      snap_q[k] <= snap_d[k];
      tail_q[k] <= tail_d[k];
    end
  end

  assign br_tag            = alloc_tag;
  assign stack_full        = full;
  assign restore_flag      = restore_q;
  assign free_list_restore = frl_q;
  assign rob_tail_restore  = rtl_q;
  assign squash_mask       = sq_q;

`ifdef BRANCH_STACK_STATS_EN
  logic [31:0] mis_cnt_q, cor_cnt_q, stall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mis_cnt_q   <= '0;
      cor_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (mis && !(&mis_cnt_q))
        mis_cnt_q <= mis_cnt_q + 32'd1;
      if (cor && !(&cor_cnt_q))
        cor_cnt_q <= cor_cnt_q + 32'd1;
      if (br_dispatch_valid && full && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_mispredicts = mis_cnt_q;
  assign stat_correct     = cor_cnt_q;
  assign stat_full_stalls = stall_cnt_q;
`endif

endmodule

// File: tb/tb_branch_stack.sv
// tb_branch_stack: directed test-plan sequences with literal checks,
// then randomized traffic compared every cycle against an age-ordered model.
module tb_branch_stack;

  logic        clock = 1'b0;
  logic        reset;
  logic        br_dispatch_valid;
  logic [63:0] br_free_list;
  logic [4:0]  br_rob_tail;
  logic [1:0]  br_tag;
  logic        stack_full;
  logic        resolve_valid;
  logic [1:0]  resolve_tag;
  logic        resolve_mispredict;
  logic [17:0] phys_reg_retiring;
  logic [1:0]  num_retiring_valid;
  logic        restore_flag;
  logic [63:0] free_list_restore;
  logic [4:0]  rob_tail_restore;
  logic [3:0]  squash_mask;
`ifdef BRANCH_STACK_STATS_EN
  logic [31:0] stat_mispredicts, stat_correct, stat_full_stalls;
`endif

  branch_stack dut (
    .clock              (clock),
    .reset              (reset),
    .br_dispatch_valid  (br_dispatch_valid),
    .br_free_list       (br_free_list),
    .br_rob_tail        (br_rob_tail),
    .br_tag             (br_tag),
    .stack_full         (stack_full),
    .resolve_valid      (resolve_valid),
    .resolve_tag        (resolve_tag),
    .resolve_mispredict (resolve_mispredict),
    .phys_reg_retiring  (phys_reg_retiring),
    .num_retiring_valid (num_retiring_valid),
    .restore_flag       (restore_flag),
    .free_list_restore  (free_list_restore),
    .rob_tail_restore   (rob_tail_restore),
    .squash_mask        (squash_mask)
`ifdef BRANCH_STACK_STATS_EN
    ,
    .stat_mispredicts   (stat_mispredicts),
    .stat_correct       (stat_correct),
    .stat_full_stalls   (stat_full_stalls)
`endif
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  // Model: entries ordered by dispatch sequence number; "younger"
  // simply means a live entry with a larger sequence number.
  bit   [3:0]  m_valid = '0;
  logic [63:0] m_snap [4];
  logic [4:0]  m_tail [4];
  int          m_seq  [4];
  int          seq_ctr = 0;
  bit          m_rf  = 0;
  logic [63:0] m_frl = '0;
  logic [4:0]  m_rtl = '0;
  logic [3:0]  m_sq  = '0;
  logic [31:0] m_smis = '0, m_scor = '0, m_sstall = '0;

  function automatic logic [1:0] exp_tag();
    for (int k = 0; k < 4; k++)
      if (!m_valid[k]) return 2'(k);
    return 2'd0;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always @(posedge clock) begin : model
    logic [63:0] ret;
    logic [3:0]  sq;
    bit          full, ok, mis, cor;
    int          t, a;
    if (reset) begin
      m_valid = '0;
      m_rf = 0; m_frl = '0; m_rtl = '0; m_sq = '0;
      m_smis = '0; m_scor = '0; m_sstall = '0;
    end else begin
      ret = '0;
      for (int i = 0; i < 3; i++)
        if (i < int'(num_retiring_valid))
          ret[phys_reg_retiring[i*6 +: 6]] = 1'b1;
      full = (m_valid == 4'hF);
      a    = int'(exp_tag());
      t    = int'(resolve_tag);
      ok   = resolve_valid && m_valid[t];
      mis  = ok && resolve_mispredict;
      cor  = ok && !resolve_mispredict;
      sq   = '0;
      if (mis)
        for (int k = 0; k < 4; k++)
          if (m_valid[k] && m_seq[k] >= m_seq[t]) sq[k] = 1'b1;
      m_rf = mis;
      m_sq = sq;
      if (mis) begin
        m_frl = m_snap[t] | ret;
        m_rtl = m_tail[t];
      end
      if (mis) m_smis = sat_inc(m_smis);
      if (cor) m_scor = sat_inc(m_scor);
      if (br_dispatch_valid && full) m_sstall = sat_inc(m_sstall);
      for (int k = 0; k < 4; k++)
        if (m_valid[k]) m_snap[k] = m_snap[k] | ret;
      m_valid = m_valid & ~sq;
      if (cor) m_valid[t] = 1'b0;
      if (br_dispatch_valid && !full && !mis) begin
        m_valid[a] = 1'b1;
        m_snap[a]  = br_free_list | ret;
        m_tail[a]  = br_rob_tail;
        m_seq[a]   = seq_ctr;
        seq_ctr++;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("br_tag", br_tag, exp_tag());
      check("stack_full", stack_full, m_valid == 4'hF);
      check("restore_flag", restore_flag, m_rf);
      check("free_list_restore", free_list_restore, m_frl);
      check("rob_tail_restore", rob_tail_restore, m_rtl);
      check("squash_mask", squash_mask, m_sq);
`ifdef BRANCH_STACK_STATS_EN
      check("stat_mispredicts", stat_mispredicts, m_smis);
      check("stat_correct", stat_correct, m_scor);
      check("stat_full_stalls", stat_full_stalls, m_sstall);
`endif
    end
  end

  task automatic go(input bit dv, input logic [63:0] fl,
                    input logic [4:0] tl, input bit rv,
                    input logic [1:0] rt, input bit mp,
                    input logic [1:0] nr, input logic [17:0] regs,
                    input bit rst);
    @(posedge clock);
    #1;
    reset              = rst;
    br_dispatch_valid  = dv;
    br_free_list       = fl;
    br_rob_tail        = tl;
    resolve_valid      = rv;
    resolve_tag        = rt;
    resolve_mispredict = mp;
    num_retiring_valid = nr;
    phys_reg_retiring  = regs;
  endtask

  task automatic idle();
    go(0, '0, '0, 0, '0, 0, '0, '0, 0);
  endtask

  task automatic disp(input logic [63:0] fl, input logic [4:0] tl);
    go(1, fl, tl, 0, '0, 0, '0, '0, 0);
  endtask

  task automatic resolve(input logic [1:0] rt, input bit mp);
    go(0, '0, '0, 1, rt, mp, '0, '0, 0);
  endtask

  initial begin
    reset = 1; br_dispatch_valid = 0; br_free_list = '0;
    br_rob_tail = '0; resolve_valid = 0; resolve_tag = '0;
    resolve_mispredict = 0; num_retiring_valid = '0;
    phys_reg_retiring = '0;
    go(0, '0, '0, 0, '0, 0, '0, '0, 1);
    chk_en = 1;
    idle(); #2;
    check("rst restore_flag", restore_flag, 0);
    check("rst squash_mask", squash_mask, 0);
    check("rst stack_full", stack_full, 0);
    check("rst br_tag", br_tag, 0);
    check("rst free_list_restore", free_list_restore, 0);

    for (int i = 0; i < 4; i++) begin
      disp(64'h0, 5'(i + 1)); #2;
      check("alloc order", br_tag, 64'(i));
    end
    go(1, '0, 5'd5, 1, 2'd0, 0, '0, '0, 0); #2;
    check("full after 4", stack_full, 1);
    idle(); #2;
    check("full after release", stack_full, 0);
    check("tag0 reusable", br_tag, 0);

    go(0, '0, '0, 0, '0, 0, '0, '0, 1);
    disp(64'hF0, 5'd7);
    disp(64'h0, 5'd8);
    disp(64'h0, 5'd9);
    resolve(2'd1, 1);
    idle(); #2;
    check("mp1 restore_flag", restore_flag, 1);
    check("mp1 squash_mask", squash_mask, 4'b0110);
    check("mp1 rob_tail", rob_tail_restore, 5'd8);
    check("mp1 free tag", br_tag, 1);
    idle(); #2;
    check("mp1 pulse ends", restore_flag, 0);
    check("mp1 mask ends", squash_mask, 0);
    check("mp1 tail holds", rob_tail_restore, 5'd8);
    resolve(2'd0, 1);
    idle(); #2;
    check("mp0 snapshot", free_list_restore, 64'hF0);
    check("mp0 squash_mask", squash_mask, 4'b0001);

    disp(64'h0, 5'd3);
    idle();
    go(0, '0, '0, 0, '0, 0, 2'd1, 18'd5, 0);
    idle();
    resolve(2'd0, 1);
    idle(); #2;
    check("retire into snapshot", free_list_restore, 64'h20);

    disp(64'h1, 5'd2);
    go(1, 64'hFF, 5'd6, 1, 2'd0, 1, 2'd1, 18'd9, 0);
    idle(); #2;
    check("same-cycle restore", free_list_restore, 64'h201);
    check("same-cycle mask", squash_mask, 4'b0001);
    check("same-cycle flag", restore_flag, 1);
    resolve(2'd1, 1);
    idle(); #2;
    check("dropped dispatch", restore_flag, 0);

    disp(64'h0, 5'd1);
    disp(64'h0, 5'd2);
    disp(64'h0, 5'd3);
    resolve(2'd1, 0);
    resolve(2'd0, 1);
    idle(); #2;
    check("post-correct mask", squash_mask, 4'b0101);
    check("post-correct tail", rob_tail_restore, 5'd1);

    resolve(2'd3, 1);
    idle(); #2;
    check("invalid tag flag", restore_flag, 0);
    check("invalid tag mask", squash_mask, 0);
    check("invalid tag state", br_tag, 0);

    for (int c = 0; c < 3000; c++) begin
      go($urandom_range(0, 99) < 55,
         {$urandom(), $urandom()},
         5'($urandom()),
         $urandom_range(0, 99) < 40,
         2'($urandom()),
         $urandom_range(0, 99) < 30,
         2'($urandom()),
         18'($urandom()),
         $urandom_range(0, 199) == 0);
    end
    idle();
    @(posedge clock);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
